// File: rtl/snake_collision_checker_pkg.sv
// snake_pkg: shared widths, playfield limits, FSM state type and segment slice helpers
package snake_pkg;
    localparam int SEG_W       = 10;
    localparam int MAX_SEGS    = 100;
    localparam int POS_W       = SEG_W * MAX_SEGS;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int INIT_LENGTH = 4;
    localparam int GROW_STEP   = 8;
    localparam int FOOD_SIZE   = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [SEG_W-1:0] FOOD_MAX_X = SEG_W'(SCREEN_W - FOOD_SIZE);
    localparam logic [SEG_W-1:0] FOOD_MAX_Y = SEG_W'(SCREEN_H - FOOD_SIZE);
    localparam logic [SEG_W-1:0] LEN_MAX    = SEG_W'(MAX_SEGS - 1);

    typedef enum logic [2:0] {IDLE, FOOD, SCAN, RESP, GEN} state_t;

    function automatic logic [SEG_W-1:0] seg_x(input logic [POS_W-1:0] pos_x, input logic [SEG_W-1:0] k);
        return pos_x[k*SEG_W +: SEG_W];
    endfunction

    function automatic logic [SEG_W-1:0] seg_y(input logic [POS_W-1:0] pos_y, input logic [SEG_W-1:0] k);
        return pos_y[k*SEG_W +: SEG_W];
    endfunction
endpackage

// File: rtl/snake_collision_checker_if.sv
// snake_collision_checker_if: controller <-> rules engine bus
//   master (controller): drives tick, pos_x, pos_y; reads length, food_x/y, busy, eat, done, game_over
//   slave  (checker)   : the reverse
interface snake_collision_checker_if;
    import snake_pkg::*;
    logic             tick;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic [SEG_W-1:0] length;
    logic [SEG_W-1:0] food_x;
    logic [SEG_W-1:0] food_y;
    logic             busy;
    logic             eat;
    logic             done;
    logic             game_over;

    modport master (output tick, pos_x, pos_y,
                    input  length, food_x, food_y, busy, eat, done, game_over);
    modport slave  (input  tick, pos_x, pos_y,
                    output length, food_x, food_y, busy, eat, done, game_over);
endinterface

// File: rtl/snake_collision_checker_food_lfsr.sv
// snake_food_lfsr: free-running 16-bit Galois LFSR with food-position accept/reject
//   clock, reset (async, active-high), req: GEN state active
//   valid: candidate fits inside the playfield; x, y: candidate food top-left
module snake_food_lfsr
    import snake_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    output logic             valid,
    output logic [SEG_W-1:0] x,
    output logic [SEG_W-1:0] y
);
    logic [15:0] lfsr_q, lfsr_d;

    // Taps 16,14,13,11 in right-shifting Galois form give the 0xB400 toggle mask.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        x      = lfsr_q[9:0];
        y      = {1'b0, lfsr_q[14:6]};
        valid  = req && x <= FOOD_MAX_X && y <= FOOD_MAX_Y;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
endmodule

// File: rtl/snake_collision_checker.sv
// snake_collision_checker: per-step food/self-collision rules engine; owns length and food position
//   clock, reset (async, active-high)
//   bus (slave): tick, pos_x, pos_y in; length, food_x, food_y, busy, eat, done, game_over out
//   SNAKE_SELF_COLLISION_EN: when defined, body segments 1..length are scanned for a head hit;
//   otherwise FOOD goes straight to RESP and game_over never rises.
module snake_collision_checker
    import snake_pkg::*;
(
    input logic                      clock,
    input logic                      reset,
    snake_collision_checker_if.slave bus
);
    state_t           state_q, state_d;
    logic [SEG_W-1:0] head_x_q, head_x_d, head_y_q, head_y_d;
    logic [SEG_W-1:0] k_q, k_d, length_q, length_d;
    logic [SEG_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
    logic             hit_q, hit_d, coll_q, coll_d;
    logic             busy_q, busy_d, eat_q, eat_d, done_q, done_d, game_over_q, game_over_d;
    logic             gen_valid, seg_hit;
    logic [SEG_W-1:0] gen_x, gen_y;
    logic [SEG_W:0]   dx, dy, grown;

    snake_food_lfsr u_lfsr (
        .clock (clock),
        .reset (reset),
        .req   (state_q == GEN),
        .valid (gen_valid),
        .x     (gen_x),
        .y     (gen_y)
    );

    always_comb begin
        state_d     = state_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        k_d         = k_q;
        length_d    = length_q;
        food_x_d    = food_x_q;
        food_y_d    = food_y_q;
        hit_d       = hit_q;
        coll_d      = coll_q;
        busy_d      = busy_q;
        eat_d       = 1'b0;
        done_d      = 1'b0;
        game_over_d = game_over_q;
        // 11-bit differences wrap high when the head is left of / above the food.
        dx          = {1'b0, head_x_q} - {1'b0, food_x_q};
        dy          = {1'b0, head_y_q} - {1'b0, food_y_q};
        grown       = {1'b0, length_q} + (SEG_W+1)'(GROW_STEP);
        seg_hit     = seg_x(bus.pos_x, k_q) == head_x_q && seg_y(bus.pos_y, k_q) == head_y_q;
        case (state_q)
            IDLE: if (bus.tick && !game_over_q) begin
                head_x_d = bus.pos_x[SEG_W-1:0];
                head_y_d = bus.pos_y[SEG_W-1:0];
                busy_d   = 1'b1;
                state_d  = FOOD;
            end
            FOOD: begin
                hit_d  = dx < (SEG_W+1)'(FOOD_SIZE) && dy < (SEG_W+1)'(FOOD_SIZE);
                coll_d = 1'b0;
                k_d    = SEG_W'(1);
`ifdef SNAKE_SELF_COLLISION_EN
                state_d = length_q == '0 ? RESP : SCAN;
`else
                state_d = RESP;
`endif
            end
            SCAN: begin
                coll_d  = coll_q || seg_hit;
                k_d     = k_q == length_q ? k_q : k_q + SEG_W'(1);
                state_d = k_q == length_q ? RESP : SCAN;
            end
            RESP: if (coll_q) begin
                game_over_d = 1'b1;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end else if (hit_q) begin
                eat_d    = 1'b1;
                length_d = grown > {1'b0, LEN_MAX} ? LEN_MAX : grown[SEG_W-1:0];
                state_d  = GEN;
            end else begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            GEN: if (gen_valid) begin
                food_x_d = gen_x;
                food_y_d = gen_y;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q     <= IDLE;
            head_x_q    <= '0;
            head_y_q    <= '0;
            k_q         <= '0;
            length_q    <= SEG_W'(INIT_LENGTH);
            food_x_q    <= SEG_W'(320);
            food_y_q    <= SEG_W'(120);
            hit_q       <= 1'b0;
            coll_q      <= 1'b0;
            busy_q      <= 1'b0;
            eat_q       <= 1'b0;
            done_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            k_q         <= k_d;
            length_q    <= length_d;
            food_x_q    <= food_x_d;
            food_y_q    <= food_y_d;
            hit_q       <= hit_d;
            coll_q      <= coll_d;
            busy_q      <= busy_d;
            eat_q       <= eat_d;
            done_q      <= done_d;
            game_over_q <= game_over_d;
        end

    assign bus.length    = length_q;
    assign bus.food_x    = food_x_q;
    assign bus.food_y    = food_y_q;
    assign bus.busy      = busy_q;
    assign bus.eat       = eat_q;
    assign bus.done      = done_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_snake_collision_checker.sv
// tb_snake_collision_checker: scoreboard bench; expectations queued at tick, checked when done pulses
module tb_snake_collision_checker;
    import snake_pkg::*;

`ifdef SNAKE_SELF_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    typedef struct {
        bit         eat;
        int         len;
        bit         go;
        bit         fnew;
        int         fx;
        int         fy;
        int         lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    snake_collision_checker_if bus();
    snake_collision_checker dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    exp_t             exp_q[$];
    int               vectors = 0, miscompares = 0;
    int               n_push = 0, n_pop = 0, cyc = 0, t0 = 0;
    int               cur_fx = 320, cur_fy = 120;
    bit               eat_seen = 1'b0;
    logic [POS_W-1:0] px, py;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) eat_seen = 1'b0;
            else begin
                if (bus.eat) eat_seen = 1'b1;
                if (bus.done) begin
                    if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        n_pop++;
                        chk("eat", int'(eat_seen), int'(e.eat));
                        chk("length", int'(bus.length), e.len);
                        chk("game_over", int'(bus.game_over), int'(e.go));
                        if (e.lat != 0) chk("latency", cyc - t0 + 1, e.lat);
                        if (e.fnew) begin
                            chk("food_x_range", int'(int'(bus.food_x) <= 632), 1);
                            chk("food_y_range", int'(int'(bus.food_y) <= 472), 1);
                            chk("food_moved", int'(int'(bus.food_x) != e.fx || int'(bus.food_y) != e.fy), 1);
                        end else begin
                            chk("food_x", int'(bus.food_x), e.fx);
                            chk("food_y", int'(bus.food_y), e.fy);
                        end
                        cur_fx = int'(bus.food_x);
                        cur_fy = int'(bus.food_y);
                    end
                    eat_seen = 1'b0;
                end
            end
        end
    end

    task automatic body_fill();
        for (int k = 1; k < MAX_SEGS; k++) begin
            px[k*SEG_W +: SEG_W] = 10'd639;
            py[k*SEG_W +: SEG_W] = 10'd479;
        end
    endtask

    task automatic step(input int hx, input int hy, input exp_t e);
        @(negedge clock);
        px[SEG_W-1:0] = SEG_W'(hx);
        py[SEG_W-1:0] = SEG_W'(hy);
        bus.pos_x = px;
        bus.pos_y = py;
        exp_q.push_back(e);
        n_push++;
        bus.tick = 1'b1;
        @(posedge clock);
        #1 bus.tick = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 400 && n_pop < n_push; i++) @(posedge clock);
        if (n_pop < n_push) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
            n_pop = n_push;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        cur_fx = 320;
        cur_fy = 120;
        exp_q.delete();
        n_pop = n_push;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_length"}, int'(bus.length), 4);
        chk({tag, "_food_x"}, int'(bus.food_x), 320);
        chk({tag, "_food_y"}, int'(bus.food_y), 120);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_eat"}, int'(bus.eat), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_game_over"}, int'(bus.game_over), 0);
    endtask

    initial begin
        int hx;
        int l;
        bus.tick = 1'b0;
        body_fill();
        px[SEG_W-1:0] = '0;
        py[SEG_W-1:0] = '0;
        bus.pos_x = px;
        bus.pos_y = py;
        repeat (2) @(negedge clock);
        chk_reset_values("reset");
        reset = 1'b0;

        // No eat, no collision: latency 3+length (3 without scanning).
        step(100, 100, '{eat:0, len:4, go:0, fnew:0, fx:320, fy:120, lat:(COLL ? 7 : 3)});
        chk("busy_after_done", int'(bus.busy), 0);

        // Head inside food box at offset (3,5): grow 4->12 and relocate food.
        step(323, 125, '{eat:1, len:12, go:0, fnew:1, fx:320, fy:120, lat:0});

        // Segment 5 sits on the head; head kept clear of wherever the food now is.
        hx = cur_fx >= 320 ? 100 : 500;
        px[5*SEG_W +: SEG_W] = SEG_W'(hx);
        py[5*SEG_W +: SEG_W] = 10'd240;
        step(hx, 240, '{eat:0, len:12, go:COLL, fnew:0, fx:cur_fx, fy:cur_fy, lat:(COLL ? 15 : 3)});
`ifdef SNAKE_SELF_COLLISION_EN
        @(negedge clock);
        bus.tick = 1'b1;
        @(negedge clock);
        bus.tick = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("busy_after_game_over", int'(bus.busy), 0);
        end
        chk("game_over_sticky", int'(bus.game_over), 1);
`endif
        body_fill();

        // Head in food box and on segment 3: collision has priority over eating.
        do_reset();
        px[3*SEG_W +: SEG_W] = 10'd322;
        py[3*SEG_W +: SEG_W] = 10'd121;
        step(322, 121, '{eat:!COLL, len:(COLL ? 4 : 12), go:COLL, fnew:!COLL, fx:320, fy:120, lat:(COLL ? 7 : 0)});
        body_fill();

        // Repeated eats: 12,20,...,92, then saturate at 99 twice.
        do_reset();
        for (int n = 0; n < 13; n++) begin
            l = 4 + 8 * (n + 1);
            l = l > 99 ? 99 : l;
            step(cur_fx, cur_fy, '{eat:1, len:l, go:0, fnew:1, fx:cur_fx, fy:cur_fy, lat:0});
        end

        // Asynchronous reset mid-evaluation, then a clean step.
        do_reset();
        @(negedge clock);
        px[SEG_W-1:0] = 10'd100;
        py[SEG_W-1:0] = 10'd100;
        bus.pos_x = px;
        bus.pos_y = py;
        bus.tick = 1'b1;
        @(posedge clock);
        #1 bus.tick = 1'b0;
        @(posedge clock);
`ifdef SNAKE_SELF_COLLISION_EN
        @(posedge clock);
`endif
        #1 reset = 1'b1;
        #1 chk_reset_values("midscan");
        @(negedge clock);
        reset = 1'b0;
        cur_fx = 320;
        cur_fy = 120;
        step(100, 100, '{eat:0, len:4, go:0, fnew:0, fx:320, fy:120, lat:(COLL ? 7 : 3)});
        repeat (10) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
